// File: rtl/sipo_piso_master_pkg.sv
// Shared configuration for the serial config master and its bench-side slave model:
// default field widths, FSM state encodings and small elaboration-time helpers.
package sipo_piso_master_pkg;

  // Register-map geometry. The master's address field is one bit wider than the map address.
  localparam int ADDR_WIDTH = 4;
  localparam int REG_WIDTH  = 8;

  // Master FSM states; 3-bit encodings are shared with the slave model in the bench.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_SHIFT_OUT = 3'd2,
    ST_TURN      = 3'd3,
    ST_SHIFT_IN  = 3'd4,
    ST_GAP       = 3'd5
  } state_e;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Phase counters are loaded with (length - 1), so log2 of the longest phase is enough.
  function automatic int ctr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sipo_piso_bit_ctr.sv
// Load/decrement phase counter with a zero flag. Loaded with (phase length - 1);
// the owning FSM leaves the phase in the cycle where zero_o is high.
module sipo_piso_bit_ctr #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: load wins over decrement; decrement saturates at zero.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/sipo_piso_master.sv
// Host-side serial config master: takes one parallel command per handshake, shifts it
// out LSB-first on the three-wire link and, for reads, shifts REG_W bits back in.
module sipo_piso_master
  import sipo_piso_master_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH + 1,
  parameter int REG_W  = REG_WIDTH,
  parameter int RD_LAT = 2,
  parameter int GAP    = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [REG_W-1:0]  cmd_wdata_i,
  input  logic              abort_i,
  output logic [REG_W-1:0]  rd_data_o,
  output logic              rd_valid_o,
  output logic              aborted_o,
  output logic              busy_o,
  output logic              strobe_o,
  output logic              wr_en_o,
  output logic              sdo_o,
  input  logic              sdi_i
);

  // A write frame is data then address, so both fit one shift register.
  localparam int SH_W  = REG_W + ADDR_W;
  localparam int CNT_W = ctr_width(max_of(max_of(SH_W, RD_LAT), GAP));

  localparam logic [CNT_W-1:0] LEN_WR   = CNT_W'(SH_W - 1);
  localparam logic [CNT_W-1:0] LEN_ADDR = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] LEN_TURN = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] LEN_RX   = CNT_W'(REG_W - 1);
  localparam logic [CNT_W-1:0] LEN_GAP  = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q;
  logic               we_q;
  logic [SH_W-1:0]    shreg_q;
  logic [REG_W-2:0]   rx_q;       // bits sampled so far; the final bit comes straight from sdi_i
  logic [REG_W-1:0]   rd_data_q;
  logic               rd_valid_q;
  logic               aborted_q;
  logic               strobe_q;
  logic               wr_en_q;
  logic               sdo_q;

  logic               ctr_load;
  logic               ctr_dec;
  logic [CNT_W-1:0]   ctr_val;
  logic [CNT_W-1:0]   ctr_count;
  logic               ctr_zero;
  logic               abort_take;

  // Abort is honoured only while a frame is on the link.
  assign abort_take = abort_i &&
                      (state_q inside {ST_START, ST_SHIFT_OUT, ST_TURN, ST_SHIFT_IN});

  sipo_piso_bit_ctr #(.W(CNT_W)) u_ctr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (ctr_load),
    .load_val_i (ctr_val),
    .dec_i      (ctr_dec),
    .count_o    (ctr_count),
    .zero_o     (ctr_zero)
  );

  // Phase counter control: load the next phase length on each phase exit, else count down.
  always_comb begin
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    ctr_val  = '0;
    if (abort_take) begin
      ctr_load = 1'b1;
      ctr_val  = LEN_GAP;
    end else begin
      case (state_q)
        ST_START: begin
          ctr_load = 1'b1;
          ctr_val  = we_q ? LEN_WR : LEN_ADDR;
        end
        ST_SHIFT_OUT: begin
          if (ctr_zero) begin
            ctr_load = 1'b1;
            ctr_val  = we_q ? LEN_GAP : LEN_TURN;
          end else begin
            ctr_dec = 1'b1;
          end
        end
        ST_TURN: begin
          if (ctr_zero) begin
            ctr_load = 1'b1;
            ctr_val  = LEN_RX;
          end else begin
            ctr_dec = 1'b1;
          end
        end
        ST_SHIFT_IN: begin
          if (ctr_zero) begin
            ctr_load = 1'b1;
            ctr_val  = LEN_GAP;
          end else begin
            ctr_dec = 1'b1;
          end
        end
        ST_GAP:  ctr_dec = !ctr_zero;
        default: ;
      endcase
    end
  end

  // Transaction FSM; all link and status outputs are registered here.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      shreg_q    <= '0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      aborted_q  <= 1'b0;
      strobe_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      sdo_q      <= 1'b0;
    end else begin
      strobe_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      aborted_q  <= 1'b0;
      if (abort_take) begin
        // A second strobe mid-frame returns the slave to idle; the cancel cycle opens GAP.
        state_q   <= ST_GAP;
        strobe_q  <= 1'b1;
        aborted_q <= 1'b1;
        wr_en_q   <= 1'b0;
        sdo_q     <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (cmd_valid_i) begin
              we_q     <= cmd_we_i;
              shreg_q  <= cmd_we_i ? {cmd_addr_i, cmd_wdata_i} : SH_W'(cmd_addr_i);
              state_q  <= ST_START;
              strobe_q <= 1'b1;
              wr_en_q  <= cmd_we_i;
              sdo_q    <= 1'b0;
            end
          end
          ST_START: begin
            sdo_q   <= shreg_q[0];
            shreg_q <= shreg_q >> 1;
            state_q <= ST_SHIFT_OUT;
          end
          ST_SHIFT_OUT: begin
            if (ctr_zero) begin
              sdo_q <= 1'b0;
              if (we_q) begin
                state_q <= ST_GAP;
                if (GAP == 1) wr_en_q <= 1'b0;
              end else begin
                state_q <= ST_TURN;
              end
            end else begin
              sdo_q   <= shreg_q[0];
              shreg_q <= shreg_q >> 1;
            end
          end
          ST_TURN: begin
            if (ctr_zero) state_q <= ST_SHIFT_IN;
          end
          ST_SHIFT_IN: begin
            if (ctr_zero) begin
              rd_data_q  <= {sdi_i, rx_q};
              rd_valid_q <= 1'b1;
              state_q    <= ST_GAP;
            end else begin
              rx_q <= {sdi_i, rx_q[REG_W-2:1]};
            end
          end
          ST_GAP: begin
            if (ctr_zero) begin
              state_q <= ST_IDLE;
            end else if (ctr_count == CNT_ONE) begin
              wr_en_q <= 1'b0;   // wr_en is low during the last GAP cycle
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign aborted_o   = aborted_q;
  assign strobe_o    = strobe_q;
  assign wr_en_o     = wr_en_q;
  assign sdo_o       = sdo_q;

endmodule

// File: tb/tb_sipo_piso_master.sv
// Bench for sipo_piso_master: directed scenarios plus random commands, checked cycle by
// cycle against a timeline model, with a serial register slave on the link.
module tb_sipo_piso_master;
  import sipo_piso_master_pkg::*;

  localparam int ADDR_W = ADDR_WIDTH + 1;
  localparam int REG_W  = REG_WIDTH;
  localparam int RD_LAT = 2;
  localparam int GAP    = 2;
  localparam int SH_W   = ADDR_W + REG_W;
  localparam int NREG   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_we = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [REG_W-1:0]  cmd_wdata = '0;
  logic              abort = 1'b0;
  logic              sdi;
  logic              cmd_ready, rd_valid, aborted, busy, strobe, wr_en, sdo;
  logic [REG_W-1:0]  rd_data;

  always #5 clk = ~clk;

  sipo_piso_master #(.ADDR_W(ADDR_W), .REG_W(REG_W), .RD_LAT(RD_LAT), .GAP(GAP)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .abort_i     (abort),
    .rd_data_o   (rd_data),
    .rd_valid_o  (rd_valid),
    .aborted_o   (aborted),
    .busy_o      (busy),
    .strobe_o    (strobe),
    .wr_en_o     (wr_en),
    .sdo_o       (sdo),
    .sdi_i       (sdi)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave register model on the link ----------------
  logic [REG_W-1:0] slave_mem [NREG];
  logic [REG_W-1:0] exp_mem   [NREG];
  logic             sl_act = 1'b0;
  logic             sl_we  = 1'b0;
  int               sl_j   = 0;
  logic [SH_W-1:0]  sl_sh  = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      sl_act <= 1'b0;
      sdi    <= 1'b0;
    end else if (strobe) begin
      sdi <= 1'b0;
      if (sl_act) begin
        sl_act <= 1'b0;                 // strobe mid-frame cancels
      end else begin
        sl_act <= 1'b1;
        sl_we  <= wr_en;
        sl_j   <= 1;
        sl_sh  <= '0;
      end
    end else if (sl_act) begin
      sl_j <= sl_j + 1;
      if (sl_we) begin
        sl_sh[sl_j-1] <= sdo;
        if (sl_j == SH_W) begin
          slave_mem[{sdo, sl_sh[SH_W-2:REG_W]}] <= sl_sh[REG_W-1:0];
          sl_act <= 1'b0;
        end
      end else begin
        if (sl_j <= ADDR_W) sl_sh[sl_j-1] <= sdo;
        if (sl_j >= ADDR_W + RD_LAT && sl_j < ADDR_W + RD_LAT + REG_W)
          sdi <= slave_mem[sl_sh[ADDR_W-1:0]][sl_j-ADDR_W-RD_LAT];
        else
          sdi <= 1'b0;
        if (sl_j == ADDR_W + RD_LAT + REG_W) sl_act <= 1'b0;
      end
    end
  end

  // ---------------- timeline reference model ----------------
  typedef struct packed {
    logic strobe, wr_en, sdo, ready, busy, rd_valid, aborted;
  } link_t;

  // Cycles from the START cycle through the last shift cycle.
  function automatic int plen(input bit we);
    return we ? 1 + SH_W : 1 + ADDR_W + RD_LAT + REG_W;
  endfunction

  // Expected outputs in cycle c after accept (c = 1 is START); a = cycle abort is held high.
  function automatic link_t model(input bit we, input logic [ADDR_W-1:0] addr,
                                  input logic [REG_W-1:0] data, input int c, input int a);
    link_t           e;
    logic [SH_W-1:0] frame;
    int              len;
    bit              ab;
    int              last_busy;
    len       = plen(we);
    frame     = we ? {addr, data} : SH_W'(addr);
    ab        = (a >= 1) && (a <= len);
    last_busy = ab ? a + GAP : len + GAP;
    e         = '0;
    e.busy    = (c <= last_busy);
    e.ready   = !e.busy;
    if (ab && c > a) begin
      e.strobe  = (c == a + 1);
      e.aborted = (c == a + 1);
      return e;
    end
    e.strobe   = (c == 1);
    e.wr_en    = we && (c < len + GAP);
    if (c >= 2 && (c - 2) < (we ? SH_W : ADDR_W)) e.sdo = frame[c-2];
    e.rd_valid = !we && (c == len + 1);
    return e;
  endfunction

  logic [REG_W-1:0] last_rd = '0;
  int               last_wait = 0;
  int               txn_no = 0;

  function automatic link_t sample();
    link_t g;
    g = '{strobe, wr_en, sdo, cmd_ready, busy, rd_valid, aborted};
    return g;
  endfunction

  // One command: wait for ready, accept, then check every cycle until ready returns.
  // noise: 0 none, 1 random addr-7 cmd_valid pulses while busy, 2 hold cmd_valid while busy.
  // rst_c: if > 0, reset is asserted in that cycle and checked in the next one.
  task automatic issue(input bit we, input logic [ADDR_W-1:0] addr, input logic [REG_W-1:0] data,
                       input int a, input int noise, input int rst_c, input bit ab_accept);
    link_t e;
    link_t rst_exp;
    bit    was_aborted;
    bit    done;
    int    w;
    w = 0;
    done = 1'b0;
    was_aborted = (a >= 1) && (a <= plen(we));
    cmd_we = we; cmd_addr = addr; cmd_wdata = data; cmd_valid = 1'b1; abort = ab_accept;
    while (!cmd_ready && w < 60) begin
      @(posedge clk); #1;
      w++;
    end
    last_wait = w;
    if (!cmd_ready) begin
      chk("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0; abort = 1'b0;
      return;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; abort = 1'b0;
    for (int c = 1; c < 200 && !done; c++) begin
      if (rst_c > 0 && c == rst_c + 1) begin
        rst_exp = '0;
        rst_exp.ready = 1'b1;
        chk($sformatf("reset_link c%0d", c), 32'(sample()), 32'(rst_exp));
        chk("reset_rd_data", 32'(rd_data), 32'd0);
        last_rd = '0;
        was_aborted = 1'b1;
        rst_n = 1'b1;
        done = 1'b1;
      end else begin
        e = model(we, addr, data, c, a);
        chk($sformatf("link c%0d", c), 32'(sample()), 32'(e));
        if (e.rd_valid) last_rd = exp_mem[addr];
        chk($sformatf("rd_data c%0d", c), 32'(rd_data), 32'(last_rd));
        if (e.ready) begin
          done = 1'b1;
        end else begin
          abort = (c == a);
          if (c == rst_c) rst_n = 1'b0;
          cmd_valid = 1'b0;
          if (noise == 2) begin
            cmd_valid = 1'b1;
          end else if (noise == 1 && $urandom_range(0, 2) == 0) begin
            cmd_valid = 1'b1; cmd_addr = 7; cmd_we = 1'($urandom); cmd_wdata = REG_W'($urandom);
          end
          @(posedge clk); #1;
        end
      end
    end
    if (!done) chk("txn_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b0; abort = 1'b0;
    if (we) begin
      if (!was_aborted) exp_mem[addr] = data;
      chk("slave_reg", 32'(slave_mem[addr]), 32'(exp_mem[addr]));
    end
    $display("txn %0d: %s addr=%0d wdata=0x%02h abort_cycle=%0d rst_cycle=%0d wait=%0d rd_data=0x%02h",
             txn_no, we ? "WR" : "RD", addr, data, a, rst_c, last_wait, rd_data);
    txn_no++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    link_t       rst_exp;
    logic [REG_W-1:0] v;
    bit          we;
    int          a, len;
    for (int i = 0; i < NREG; i++) begin
      v = REG_W'($urandom);
      slave_mem[i] <= v;
      exp_mem[i]   = v;
    end

    // Reset state, checked while reset is held and just after release.
    rst_exp = '0;
    rst_exp.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'(sample()), 32'(rst_exp));
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_state", 32'(sample()), 32'(rst_exp));

    // Reset during the first read: link drops, rd_data stays 0.
    issue(1'b0, 5'd2, 8'h00, 0, 0, 10, 1'b0);

    // Directed write addr 5 data 0x3C, then read back 0xAA from addr 2.
    issue(1'b1, 5'd5, 8'h3C, 0, 0, 0, 1'b0);
    slave_mem[2] <= 8'hAA;
    exp_mem[2]   = 8'hAA;
    issue(1'b0, 5'd2, 8'h00, 0, 0, 0, 1'b0);
    chk("read_aa", 32'(rd_data), 32'hAA);

    // Back-to-back: write held valid, read accepted on the first ready cycle.
    issue(1'b1, 5'd1, 8'hFF, 0, 2, 0, 1'b0);
    issue(1'b0, 5'd1, 8'h00, 0, 0, 0, 1'b0);
    chk("b2b_accept_wait", 32'(last_wait), 32'd0);
    chk("b2b_read_ff", 32'(rd_data), 32'hFF);

    // Abort at cycle 4 of a write: slave register must be untouched.
    issue(1'b1, 5'd9, ~exp_mem[9], 4, 0, 0, 1'b0);

    // cmd_valid for addr 7 while busy is ignored; abort coinciding with accept is ignored.
    issue(1'b0, 5'd3, 8'h00, 0, 1, 0, 1'b0);
    chk("addr7_untouched", 32'(slave_mem[7]), 32'(exp_mem[7]));
    issue(1'b1, 5'd12, 8'h5A, 0, 0, 0, 1'b1);

    // Random commands, aborts (mid-frame and during GAP) and idle spacing.
    for (int n = 0; n < 60; n++) begin
      we  = 1'($urandom);
      len = plen(we);
      a   = 0;
      case ($urandom_range(0, 7))
        0, 1: a = $urandom_range(1, len - 1);
        2:    a = $urandom_range(len + 1, len + GAP);
        default: a = 0;
      endcase
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      issue(we, ADDR_W'($urandom), REG_W'($urandom), a, $urandom_range(0, 1), 0,
            ($urandom_range(0, 5) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
